mc6809e_clkgen: RTL

MC6809E_CLKGEN -- requirements
Module: mc6809e_clkgen

---
 rtl/mc6809e_clkgen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mc6809e_clkgen.sv
// mc6809e_clkgen -- E/Q clock and power-on reset generator for an MC6809E.
//
// Parameters
//   PHASE_CLKS   : CLK cycles per quarter-phase of the E/Q cycle (1..255)
//   RESET_CYCLES : completed E cycles that RESET is held after release (1..65535)
//
// Ports
//   CLK        in   master clock, all state changes on its rising edge
//   nRESET     in   synchronous active-low reset
//   STRETCH    in   request to hold E high (slow-device wait), sampled only
//                   on the last CLK of P3
//   E, Q       out  CPU clocks, driven straight from flops
//   E_RISE, E_FALL, Q_RISE, Q_FALL
//              out  one-CLK strobes, high in the cycle the new level appears
//   RESET      out  active-high CPU reset
//   STRETCHING out  high during every cycle of an E-high extension
//   phase      out  current quarter-phase (0..3), debug visibility of the FSM
//
// Handshake: there is no valid/ready interface; STRETCH is a level that is
// only looked at on the edge that would move P3 -> P0 (or end an extension).
module mc6809e_clkgen #(
   parameter int PHASE_CLKS   = 1,
   parameter int RESET_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       STRETCH,
   output logic       E,
   output logic       Q,
   output logic       E_RISE,
   output logic       E_FALL,
   output logic       Q_RISE,
   output logic       Q_FALL,
   output logic       RESET,
   output logic       STRETCHING,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      P0 = 2'd0,   // E=0 Q=0
      P1 = 2'd1,   // E=0 Q=1
      P2 = 2'd2,   // E=1 Q=1
      P3 = 2'd3    // E=1 Q=0
   } phase_t;

   localparam logic [7:0]  QLAST     = 8'(PHASE_CLKS - 1);
   localparam logic [15:0] RST_START = 16'(RESET_CYCLES);

   phase_t      state, state_nx;
   logic [7:0]  qcnt, qcnt_nx;
   logic [15:0] rcnt, rcnt_nx;
   logic        e_nx, q_nx;
   logic        e_rise_nx, e_fall_nx, q_rise_nx, q_fall_nx;
   logic        reset_nx, stretching_nx;

   assign phase = state;

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state      <= P0;
         qcnt       <= '0;
         rcnt       <= RST_START;
         E          <= 1'b0;
         Q          <= 1'b0;
         E_RISE     <= 1'b0;
         E_FALL     <= 1'b0;
         Q_RISE     <= 1'b0;
         Q_FALL     <= 1'b0;
         RESET      <= 1'b1;
         STRETCHING <= 1'b0;
      end else begin
         state      <= state_nx;
         qcnt       <= qcnt_nx;
         rcnt       <= rcnt_nx;
         E          <= e_nx;
         Q          <= q_nx;
         E_RISE     <= e_rise_nx;
         E_FALL     <= e_fall_nx;
         Q_RISE     <= q_rise_nx;
         Q_FALL     <= q_fall_nx;
         RESET      <= reset_nx;
         STRETCHING <= stretching_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      qcnt_nx       = qcnt + 8'd1;
      rcnt_nx       = rcnt;
      e_rise_nx     = 1'b0;
      e_fall_nx     = 1'b0;
      q_rise_nx     = 1'b0;
      q_fall_nx     = 1'b0;
      reset_nx      = RESET;
      stretching_nx = STRETCHING;

      if (qcnt == QLAST) begin
         qcnt_nx = '0;
         unique case (state)
            P0: begin state_nx = P1; q_rise_nx = 1'b1; end
            P1: begin state_nx = P2; e_rise_nx = 1'b1; end
            P2: begin state_nx = P3; q_fall_nx = 1'b1; end
            P3: begin
               // Both the nominal end of P3 and the end of each extension
               // unit land here, so one sample point covers re-sampling too.
               if (STRETCH) begin
                  stretching_nx = 1'b1;
               end else begin
                  state_nx      = P0;
                  stretching_nx = 1'b0;
                  e_fall_nx     = 1'b1;
               end
            end
         endcase
      end

      // E/Q come from the next phase so the output flops update in the
      // same cycle as the phase register.
      e_nx = (state_nx == P2) || (state_nx == P3);
      q_nx = (state_nx == P1) || (state_nx == P2);

      // Counter reaching zero and RESET dropping coincide with the E_FALL.
      if (e_fall_nx && RESET) begin
         rcnt_nx = rcnt - 16'd1;
         if (rcnt == 16'd1) reset_nx = 1'b0;
      end
   end

endmodule
